// File: rtl/jtframe_lfbuf_ring.sv
// rtl/jtframe_lfbuf_ring.sv - line-slot ring frame buffer with external 16-bit memory port
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   vrender, hdump              render line and screen pixel counter
//   vs, lvbl, hs                sync/blank inputs (frame swap, line range capture, scan fetch)
//   ln_hs, ln_v                 core handshake: start drawing line ln_v
//   ln_addr, ln_data, ln_we     core pixel writes into the current slot
//   ln_done                     core finished the current line
//   ln_pxl                      screen pixel at hdump, 1-cycle latency
//   frame                       frame being written; scan reads use ~frame
//   mem_*                       external memory burst port
//   ovf                         sticky scan-fetch overrun, cleared at vs
module jtframe_lfbuf_ring #(
  parameter int DW    = 16,
  parameter int VW    = 8,
  parameter int HW    = 9,
  parameter int LINES = 4,
  parameter int HLEN  = 256,
  parameter logic [DW-1:0] CLR = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [VW-1:0]   vrender,
  input  logic [HW-1:0]   hdump,
  input  logic            vs,
  input  logic            lvbl,
  input  logic            hs,
  output logic            ln_hs,
  output logic [VW-1:0]   ln_v,
  input  logic [HW-1:0]   ln_addr,
  input  logic [DW-1:0]   ln_data,
  input  logic            ln_we,
  input  logic            ln_done,
  output logic [DW-1:0]   ln_pxl,
  output logic            frame,
  output logic [VW+HW:0]  mem_addr,
  output logic [15:0]     mem_din,
  output logic            mem_wr,
  output logic            mem_rd,
  input  logic            mem_ack,
  input  logic [15:0]     mem_dout,
  output logic            ovf
);

  localparam int SW = $clog2(LINES);

  if (DW > 16) begin : g_dw_check
    $error("jtframe_lfbuf_ring: DW must be at most 16");
  end

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t            st, st_nxt;
  logic [SW:0]       count;
  logic [SW-1:0]     wr_slot, rd_slot;
  logic [HW-1:0]     h;
  logic              vs_l, hs_l, lvbl_l;
  logic              done, hs_pend, wframe;
  logic              fetch_pend;
  logic [VW-1:0]     fetch_line, rd_line;
  logic [VW-1:0]     vstart, vend;
  logic [DW-1:0]     wr_pxl;

  // Slot storage: one 2**HW region per slot so {slot, pixel} indexes directly.
  logic [DW-1:0]     slot_mem [0:(LINES << HW)-1];
  logic [VW-1:0]     slot_line [0:LINES-1];
  logic [DW-1:0]     scan_mem [0:(2 << HW)-1];

  logic vs_rise, hs_rise, burst_last, wr_ack, rd_ack, done_ok, wr_fin;
  logic start_wr, start_rd;

  assign vs_rise    = vs & ~vs_l;
  assign hs_rise    = hs & ~hs_l;
  assign burst_last = mem_ack && (h == HW'(HLEN - 1));
  assign wr_ack     = (st == WRITE) && mem_ack;
  assign rd_ack     = (st == READ) && mem_ack;
  assign wr_fin     = (st == WRITE) && burst_last;
  assign done_ok    = ln_done && !done;
  assign start_wr   = (st == IDLE) && (st_nxt == WRITE);
  assign start_rd   = (st == IDLE) && (st_nxt == READ);

  always_comb begin
    st_nxt   = st;
    mem_wr   = 1'b0;
    mem_rd   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    case (st)
      IDLE: begin
        if (fetch_pend)       st_nxt = READ;
        else if (count != '0) st_nxt = WRITE;
      end
      WRITE: begin
        mem_wr   = 1'b1;
        mem_addr = {wframe, slot_line[rd_slot], h};
        mem_din  = 16'(wr_pxl);
        if (burst_last) st_nxt = IDLE;
      end
      READ: begin
        mem_rd   = 1'b1;
        mem_addr = {~frame, rd_line, h};
        if (burst_last) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      count      <= '0;
      wr_slot    <= '0;
      rd_slot    <= '0;
      h          <= '0;
      vs_l       <= 1'b0;
      hs_l       <= 1'b0;
      lvbl_l     <= 1'b0;
      done       <= 1'b0;
      hs_pend    <= 1'b0;
      wframe     <= 1'b0;
      fetch_pend <= 1'b0;
      fetch_line <= '0;
      rd_line    <= '0;
      ln_hs      <= 1'b0;
      ln_v       <= '0;
      ln_pxl     <= '0;
      frame      <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      st     <= st_nxt;
      vs_l   <= vs;
      hs_l   <= hs;
      lvbl_l <= lvbl;
      ln_hs  <= 1'b0;
      ln_pxl <= scan_mem[{vrender[0], hdump}];

      // A pending line request waits until the ring has a free slot.
      if (hs_pend && count != (SW+1)'(LINES)) begin
        ln_hs   <= 1'b1;
        hs_pend <= 1'b0;
      end
      if (done_ok) begin
        wr_slot <= wr_slot + 1'b1;
        if (ln_v == vend) begin
          done <= 1'b1;
        end else begin
          ln_v    <= ln_v + 1'b1;
          hs_pend <= 1'b1;
        end
      end
      count <= count + (SW+1)'(done_ok) - (SW+1)'(wr_fin);
      if (wr_fin) rd_slot <= rd_slot + 1'b1;

      if (start_wr) wframe <= frame;
      if (start_rd) begin
        rd_line    <= fetch_line;
        fetch_pend <= 1'b0;
      end
      if (wr_ack || rd_ack) h <= burst_last ? '0 : h + 1'b1;

      // A newer fetch overrides an unserved one; a burst in flight finishes.
      if (hs_rise && lvbl) begin
        if (fetch_pend || st == READ) ovf <= 1'b1;
        fetch_pend <= 1'b1;
        fetch_line <= vrender + 1'b1;
      end

      if (vs_rise) begin
        frame   <= ~frame;
        ln_v    <= vstart;
        done    <= 1'b0;
        ovf     <= 1'b0;
        hs_pend <= 1'b1;
      end
    end
  end

  // Line range capture survives reset.
  always_ff @(posedge clk) begin
    if (!lvbl && lvbl_l) vend   <= vrender;
    if (lvbl && !lvbl_l) vstart <= vrender;
  end

  // Storage arrays; the clear-behind write comes last so it wins on a slot clash.
  always_ff @(posedge clk) begin
    if (ln_we)   slot_mem[{wr_slot, ln_addr}] <= ln_data;
    if (wr_ack)  slot_mem[{rd_slot, h}] <= CLR;
    if (done_ok) slot_line[wr_slot] <= ln_v;
    if (rd_ack)  scan_mem[{rd_line[0], h}] <= mem_dout[DW-1:0];
    // Prefetch keeps mem_din valid for the word currently offered.
    if (start_wr)    wr_pxl <= slot_mem[{rd_slot, {HW{1'b0}}}];
    else if (wr_ack) wr_pxl <= slot_mem[{rd_slot, h + 1'b1}];
  end

endmodule

// File: tb/tb_jtframe_lfbuf_ring.sv
// tb/tb_jtframe_lfbuf_ring.sv - self-checking bench for jtframe_lfbuf_ring
module tb_jtframe_lfbuf_ring;

  localparam int DW = 16, VW = 8, HW = 9, LINES = 4, HLEN = 32;
  localparam int AW = VW + HW + 1;

  logic          clk, rst_n;
  logic [VW-1:0] vrender;
  logic [HW-1:0] hdump;
  logic          vs, lvbl, hs;
  logic          ln_hs;
  logic [VW-1:0] ln_v;
  logic [HW-1:0] ln_addr;
  logic [DW-1:0] ln_data;
  logic          ln_we, ln_done;
  logic [DW-1:0] ln_pxl;
  logic          frame;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_din;
  logic          mem_wr, mem_rd, mem_ack;
  logic [15:0]   mem_dout;
  logic          ovf;
  logic          ack_en;

  jtframe_lfbuf_ring #(.DW(DW), .VW(VW), .HW(HW), .LINES(LINES), .HLEN(HLEN), .CLR('0)) dut (
    .clk(clk), .rst_n(rst_n), .vrender(vrender), .hdump(hdump), .vs(vs), .lvbl(lvbl),
    .hs(hs), .ln_hs(ln_hs), .ln_v(ln_v), .ln_addr(ln_addr), .ln_data(ln_data),
    .ln_we(ln_we), .ln_done(ln_done), .ln_pxl(ln_pxl), .frame(frame),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_ack(mem_ack), .mem_dout(mem_dout), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rdat(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hA5C3;
  endfunction

  assign mem_ack  = ack_en;
  assign mem_dout = rdat(mem_addr);

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  typedef struct {
    logic [VW-1:0] line;
    logic          we;
    logic [HW-1:0] addr;
    logic [DW-1:0] data;
  } draw_t;

  typedef struct {
    logic [HW-1:0] hd;
    logic [DW-1:0] pxl;
  } scan_t;

  wr_t   exp_q[$];
  int    checks = 0;
  int    errors = 0;
  logic  tframe = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One clock; write words accepted in this cycle are scored at the negedge.
  task automatic tick();
    wr_t e;
    @(negedge clk);
    if (mem_wr && mem_ack) begin
      chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.addr));
        chk("wr_data", 32'(mem_din), 32'(e.data));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_line(input logic [VW-1:0] line, input logic we,
                           input logic [HW-1:0] addr, input logic [DW-1:0] data);
    wr_t e;
    for (int i = 0; i < HLEN; i++) begin
      e.addr = {tframe, line, HW'(i)};
      e.data = (we && HW'(i) == addr) ? 16'(data) : 16'h0;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_hs(input int budget, output int n);
    n = 0;
    while (!ln_hs && n < budget) begin
      tick();
      n++;
    end
    chk("ln_hs_seen", 32'(ln_hs), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int q = 0;
    int n = 0;
    while (q < 4 && n < budget) begin
      tick();
      n++;
      if (exp_q.size() == 0 && !mem_wr && !mem_rd) q++;
      else q = 0;
    end
    chk("bus_idle", 32'(q >= 4), 32'd1);
  endtask

  task automatic done_pulse();
    ln_done = 1'b1;
    tick();
    ln_done = 1'b0;
  endtask

  task automatic set_range(input logic [VW-1:0] vs_line, input logic [VW-1:0] ve_line);
    vrender = ve_line; lvbl = 1'b0;
    tick(); tick();
    vrender = vs_line; lvbl = 1'b1;
    tick(); tick();
  endtask

  draw_t dt[6];
  scan_t st[4];

  initial begin
    int n, seen;

    dt[0] = '{8'd16, 1'b1, 9'd5,  16'h1234};
    dt[1] = '{8'd17, 1'b1, 9'd0,  16'h00FF};
    dt[2] = '{8'd18, 1'b1, 9'd31, 16'h8001};
    dt[3] = '{8'd19, 1'b1, 9'd12, 16'h0001};
    dt[4] = '{8'd20, 1'b0, 9'd5,  16'h0000};
    dt[5] = '{8'd21, 1'b1, 9'd7,  16'hBEEF};
    st[0] = '{9'd7,  rdat({1'b1, 8'd41, 9'd7})};
    st[1] = '{9'd0,  rdat({1'b1, 8'd41, 9'd0})};
    st[2] = '{9'd31, rdat({1'b1, 8'd41, 9'd31})};
    st[3] = '{9'd12, rdat({1'b1, 8'd41, 9'd12})};

    rst_n = 1'b0; vrender = '0; hdump = '0; vs = 1'b0; lvbl = 1'b1; hs = 1'b0;
    ln_addr = '0; ln_data = '0; ln_we = 1'b0; ln_done = 1'b0; ack_en = 1'b0;
    tick(); tick();
    chk("rst_ln_hs", 32'(ln_hs), 0);
    chk("rst_ln_v", 32'(ln_v), 0);
    chk("rst_frame", 32'(frame), 0);
    chk("rst_mem_wr", 32'(mem_wr), 0);
    chk("rst_mem_rd", 32'(mem_rd), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_din", 32'(mem_din), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_ln_pxl", 32'(ln_pxl), 0);
    rst_n = 1'b1;
    tick();

    // Frame 1: lines 16..21 drawn with continuous acks
    set_range(8'd16, 8'd21);
    ack_en = 1'b1;
    vs = 1'b1; tframe = ~tframe;
    wait_hs(20, n);
    chk("vs_frame", 32'(frame), 32'(tframe));
    seen = 0;
    repeat (5) begin tick(); if (ln_hs) seen++; end
    chk("vs_single_hs", 32'(seen), 0);
    vs = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) wait_hs(2000, n);
      chk("draw_ln_v", 32'(ln_v), 32'(dt[i].line));
      if (dt[i].we) begin
        ln_addr = dt[i].addr; ln_data = dt[i].data; ln_we = 1'b1;
        tick();
        ln_we = 1'b0;
      end
      push_line(dt[i].line, dt[i].we, dt[i].addr, dt[i].data);
      done_pulse();
    end
    seen = 0;
    repeat (40) begin tick(); if (ln_hs) seen++; end
    chk("no_hs_after_vend", 32'(seen), 0);
    wait_idle(2000);

    // Frame 2: ring fills with acks held off
    ack_en = 1'b0;
    set_range(8'd30, 8'd60);
    vs = 1'b1; tframe = ~tframe;
    for (int i = 0; i < LINES; i++) begin
      wait_hs(20, n);
      chk("fill_ln_v", 32'(ln_v), 32'(30 + i));
      push_line(VW'(30 + i), 1'b0, '0, '0);
      done_pulse();
      vs = 1'b0;
    end
    seen = 0;
    repeat (30) begin tick(); if (ln_hs) seen++; end
    chk("full_no_hs", 32'(seen), 0);
    chk("full_ln_v", 32'(ln_v), 34);
    ack_en = 1'b1;
    wait_hs(HLEN + 10, n);
    chk("free_hs_latency", 32'(n >= HLEN && n <= HLEN + 2), 1);
    chk("free_ln_v", 32'(ln_v), 34);
    push_line(8'd34, 1'b0, '0, '0);
    done_pulse();
    wait_idle(2000);

    // Scan fetch: ignored in blank, then line 41 fetched from the other frame
    vrender = 8'd30; lvbl = 1'b0;
    tick();
    hs = 1'b1; tick(); hs = 1'b0;
    seen = 0;
    repeat (5) begin tick(); if (mem_rd) seen++; end
    chk("blank_no_fetch", 32'(seen), 0);
    lvbl = 1'b1;
    tick(); tick();
    vrender = 8'd40;
    hs = 1'b1; tick(); hs = 1'b0;
    n = 0;
    while (!mem_rd && n < 10) begin tick(); n++; end
    chk("fetch_rd", 32'(mem_rd), 1);
    chk("fetch_addr", 32'(mem_addr), 32'({~tframe, 8'd41, 9'd0}));
    wait_idle(500);
    chk("fetch_no_ovf", 32'(ovf), 0);
    vrender = 8'd41;
    for (int i = 0; i < 4; i++) begin
      hdump = st[i].hd;
      tick();
      chk("scan_pxl", 32'(ln_pxl), 32'(st[i].pxl));
    end

    // Overrun: fetch pending behind a stalled write, then a second hs
    ack_en = 1'b0;
    push_line(8'd35, 1'b0, '0, '0);
    done_pulse();
    tick(); tick();
    chk("ovf_wr_busy", 32'(mem_wr), 1);
    vrender = 8'd40;
    hs = 1'b1; tick(); hs = 1'b0; tick();
    chk("ovf_first_hs", 32'(ovf), 0);
    hs = 1'b1; tick(); hs = 1'b0; tick();
    chk("ovf_second_hs", 32'(ovf), 1);
    ack_en = 1'b1;
    wait_idle(1000);
    chk("ovf_sticky", 32'(ovf), 1);
    vs = 1'b1; tframe = ~tframe;
    tick();
    chk("ovf_vs_clear", 32'(ovf), 0);
    chk("ovf_vs_frame", 32'(frame), 32'(tframe));
    wait_hs(20, n);
    chk("ovf_vs_ln_v", 32'(ln_v), 30);
    vs = 1'b0;

    // Reset in the middle of a stalled write burst
    ack_en = 1'b0;
    done_pulse();
    tick(); tick();
    chk("mid_wr_active", 32'(mem_wr), 1);
    rst_n = 1'b0;
    #1;
    tframe = 1'b0;
    chk("async_mem_wr", 32'(mem_wr), 0);
    chk("async_mem_rd", 32'(mem_rd), 0);
    chk("async_ln_hs", 32'(ln_hs), 0);
    chk("async_ovf", 32'(ovf), 0);
    chk("async_frame", 32'(frame), 0);
    tick(); tick();
    ack_en = 1'b1;
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin tick(); if (mem_wr || mem_rd || ln_hs) seen++; end
    chk("post_rst_idle", 32'(seen), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
